// File: rtl/word_scroller.sv
// rtl/word_scroller.sv - rotating character display with manual offset and prescaled auto scroll
module word_scroller #(
  parameter int NUM_DIGITS = 4,
  parameter int CHAR_W     = 2,
  parameter int TICK_DIV   = 50_000_000,
  localparam int OFF_W     = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS),
  localparam int MSG_W     = NUM_DIGITS * CHAR_W
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             load,
  input  logic [MSG_W-1:0] CHARS,
  input  logic             mode,
  input  logic             dir,
  input  logic             pause,
  input  logic [OFF_W-1:0] sel,
  output logic [MSG_W-1:0] DISP,
  output logic [OFF_W-1:0] offset,
  output logic             step
);

  localparam int PS_W = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t           state_q;
  logic [MSG_W-1:0] msg_q;
  logic [OFF_W-1:0] offset_q;
  logic [PS_W-1:0]  presc_q;
  logic             step_q;

  logic [OFF_W-1:0] offset_adv_d;
  logic             sel_ok;
  logic             tick;

  // Next offset for an auto advance, wrapping at both ends of the digit range
  always_comb begin
    offset_adv_d = offset_q;
    if (dir == 1'b0) begin
      offset_adv_d = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
    end else begin
      offset_adv_d = (offset_q == '0) ? OFF_LAST : offset_q - 1'b1;
    end
  end

  assign sel_ok = (int'(sel) < NUM_DIGITS);
  assign tick   = (presc_q == PS_LAST);

  // Control FSM: state, message, offset, prescaler and step pulse all registered here
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_MANUAL;
      msg_q    <= '0;
      offset_q <= '0;
      presc_q  <= '0;
      step_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;

      if (load) begin
        msg_q <= CHARS;
      end

      // mode dominates pause in every state
      if (mode == 1'b0) begin
        state_q <= ST_MANUAL;
      end else if (pause) begin
        state_q <= ST_HOLD;
      end else begin
        state_q <= ST_AUTO;
      end

      unique case (state_q)
        ST_MANUAL: begin
          presc_q <= '0;
          if (sel_ok) begin
            offset_q <= sel;
          end
        end
        ST_AUTO: begin
          // a load restarts the scroll from the first character and swallows any tick
          if (load) begin
            offset_q <= '0;
            presc_q  <= '0;
          end else if (tick) begin
            presc_q  <= '0;
            offset_q <= offset_adv_d;
            step_q   <= 1'b1;
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        ST_HOLD: begin
          // partial count is kept so resume picks up where it left off
          if (load) begin
            offset_q <= '0;
            presc_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_MANUAL;
        end
      endcase
    end
  end

  // Rotate the message: digit i shows character (i + offset) mod NUM_DIGITS
  always_comb begin
    DISP = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      int k;
      k = i + int'(offset_q);
      if (k >= NUM_DIGITS) begin
        k = k - NUM_DIGITS;
      end
      DISP[i*CHAR_W +: CHAR_W] = msg_q[k*CHAR_W +: CHAR_W];
    end
  end

  assign offset = offset_q;
  assign step   = step_q;

endmodule

// File: doc/word_scroller.md
WORD_SCROLLER -- requirements
Module: word_scroller

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of display digits; legal range 2..8.
REQ-002 Parameter CHAR_W, default 2, bits per character code.
REQ-003 Parameter TICK_DIV, default 50_000_000, clock cycles per auto-scroll step; legal range >= 2.
REQ-004 Derived OFF_W = max(1, clog2(NUM_DIGITS)).
REQ-005 CLOCK_50  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 load  in  1  capture CHARS into message register this edge.
REQ-008 CHARS  in  NUM_DIGITS*CHAR_W  message; character k at bits [k*CHAR_W +: CHAR_W].
REQ-009 mode  in  1  0 = manual offset from sel, 1 = auto scroll.
REQ-010 dir  in  1  auto direction: 0 = offset increments, 1 = offset decrements.
REQ-011 pause  in  1  freeze auto scroll while high.
REQ-012 sel  in  OFF_W  manual rotation offset.
REQ-013 DISP  out  NUM_DIGITS*CHAR_W  rotated message; digit i at bits [i*CHAR_W +: CHAR_W].
REQ-014 offset  out  OFF_W  current rotation offset, always < NUM_DIGITS.
REQ-015 step  out  1  one-cycle pulse on each auto advance.

Function
REQ-016 Registers: msg (NUM_DIGITS*CHAR_W), offset, prescaler (0..TICK_DIV-1), state, step.
REQ-017 DISP digit i SHALL equal msg character (i + offset) mod NUM_DIGITS, combinationally from registers (zero added latency).
REQ-018 FSM states MANUAL, AUTO, HOLD; MANUAL->AUTO when mode=1 and pause=0; MANUAL->HOLD when mode=1 and pause=1; AUTO->HOLD when pause=1; HOLD->AUTO when pause=0; AUTO or HOLD->MANUAL when mode=0 (mode has priority over pause).
REQ-019 MANUAL: offset <= sel each edge (1-cycle latency) when sel < NUM_DIGITS; sel >= NUM_DIGITS leaves offset unchanged; prescaler <= 0.
REQ-020 AUTO: prescaler increments each edge; at edge where prescaler == TICK_DIV-1: prescaler <= 0, offset <= (offset+1) mod NUM_DIGITS if dir=0 else (offset-1) mod NUM_DIGITS, step <= 1.
REQ-021 Wrap: offset NUM_DIGITS-1 increments to 0; offset 0 decrements to NUM_DIGITS-1.
REQ-022 step SHALL be 0 on every edge not meeting REQ-020; never high two consecutive cycles.
REQ-023 HOLD: prescaler and offset frozen (not cleared); resume continues the partial count.
REQ-024 Entering AUTO from MANUAL: prescaler starts at 0; offset keeps last manual value; first advance TICK_DIV edges after the state register reads AUTO.
REQ-025 load=1: msg <= CHARS in any state; in AUTO/HOLD also offset <= 0, prescaler <= 0, step <= 0; load wins over a coincident tick.
REQ-026 dir change mid-count takes effect at next advance; prescaler not disturbed.

Reset
REQ-027 reset=1 at an edge: msg=0, offset=0, prescaler=0, state=MANUAL, step=0, hence DISP=0; reset overrides load, mode and all other inputs.
REQ-028 Reset asserted mid-count discards the partial count; after release the block behaves as from power-up.

Verification (NUM_DIGITS=4, CHAR_W=2, TICK_DIV=4)
REQ-029 reset, then load with CHARS=8'hE4, mode=0, sel=0 -> DISP=8'hE4, offset=0, step=0.
REQ-030 mode=0, sel=1 -> one cycle later offset=1, DISP=8'h39; sel=3 -> offset=3, DISP=8'h93.
REQ-031 From offset=0, mode=1, dir=0 -> step pulses every 4 cycles; offset 1,2,3,0; DISP 8'h39,8'h4E,8'h93,8'hE4.
REQ-032 mode=1, dir=1 from offset=0 -> first step gives offset=3, DISP=8'h93 (wrap down).
REQ-033 AUTO with prescaler=2, pause=1 for 10 cycles, then pause=0 -> no step during pause; step exactly 2 cycles after resume.
REQ-034 load with CHARS=8'h1B coincident with tick edge in AUTO -> offset=0, step=0, DISP=8'h1B; reset mid-AUTO -> all outputs 0, state MANUAL.
